mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between I-cache fills, D-cache
// fills and D-cache write-through stores. A fill is an 8-word burst over one 16-byte block.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic [15:0] dcache_addr,
  input  logic        dcache_wr_req,
  input  logic [15:0] dcache_wr_addr,
  input  logic [15:0] dcache_wr_data,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic        icache_grant,
  output logic        dcache_grant,
  output logic        icache_data_valid,
  output logic        dcache_data_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        dcache_wr_done
);

  localparam int QW = $clog2(MEM_LATENCY + 1);
  localparam logic [QW-1:0] QLAST = QW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    QUIESCE = 3'd0,
    IDLE    = 3'd1,
    ISSUE   = 3'd2,
    DRAIN   = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          owner_is_d_q, owner_is_d_d;
  logic [11:0]   base_q, base_d;
  logic [2:0]    issue_cnt_q, issue_cnt_d;
  logic [2:0]    ret_cnt_q, ret_cnt_d;
  logic [QW-1:0] quiesce_cnt_q, quiesce_cnt_d;
  logic [15:0]   wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;

  logic in_burst;
  logic word_ret;
  logic last_ret;
  logic unused_low_addr;

  // Block offset bits of a miss address never reach memory; the burst rebuilds them.
  assign unused_low_addr = ^{icache_addr[3:0], dcache_addr[3:0]};

  assign in_burst = (state_q == ISSUE) || (state_q == DRAIN);
  assign word_ret = in_burst && mem_data_valid;
  assign last_ret = word_ret && (ret_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= QUIESCE;
      owner_is_d_q  <= 1'b0;
      base_q        <= 12'h000;
      issue_cnt_q   <= 3'd0;
      ret_cnt_q     <= 3'd0;
      quiesce_cnt_q <= '0;
      wr_addr_q     <= 16'h0000;
      wr_data_q     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      owner_is_d_q  <= owner_is_d_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
      quiesce_cnt_q <= quiesce_cnt_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_is_d_d      = owner_is_d_q;
    base_d            = base_q;
    issue_cnt_d       = issue_cnt_q;
    ret_cnt_d         = ret_cnt_q;
    quiesce_cnt_d     = quiesce_cnt_q;
    wr_addr_d         = wr_addr_q;
    wr_data_d         = wr_data_q;
    mem_enable        = 1'b0;
    mem_wr            = 1'b0;
    mem_addr          = 16'h0000;
    mem_data_out      = 16'h0000;
    icache_grant      = 1'b0;
    dcache_grant      = 1'b0;
    icache_data_valid = 1'b0;
    dcache_data_valid = 1'b0;
    fill_data         = mem_data_in;
    fill_word         = 3'd0;
    icache_fill_done  = 1'b0;
    dcache_fill_done  = 1'b0;
    dcache_wr_done    = 1'b0;

    case (state_q)
      QUIESCE: begin
        // Long enough for every return of a burst cut off by reset to drain away.
        quiesce_cnt_d = quiesce_cnt_q + QW'(1);
        if (quiesce_cnt_q == QLAST) state_d = IDLE;
        else                        state_d = QUIESCE;
      end
      IDLE: begin
        if (dcache_req) begin
          owner_is_d_d = 1'b1;
          base_d       = dcache_addr[15:4];
          issue_cnt_d  = 3'd0;
          ret_cnt_d    = 3'd0;
          state_d      = ISSUE;
        end else if (dcache_wr_req) begin
          wr_addr_d = dcache_wr_addr;
          wr_data_d = dcache_wr_data;
          state_d   = WRITE;
        end else if (icache_req) begin
          owner_is_d_d = 1'b0;
          base_d       = icache_addr[15:4];
          issue_cnt_d  = 3'd0;
          ret_cnt_d    = 3'd0;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        mem_enable  = 1'b1;
        mem_addr    = {base_q, issue_cnt_q, 1'b0};
        issue_cnt_d = issue_cnt_q + 3'd1;
        if (last_ret)                  state_d = IDLE;
        else if (issue_cnt_q == 3'd7)  state_d = DRAIN;
        else                           state_d = ISSUE;
      end
      DRAIN: begin
        if (last_ret) state_d = IDLE;
        else          state_d = DRAIN;
      end
      WRITE: begin
        mem_enable     = 1'b1;
        mem_wr         = 1'b1;
        mem_addr       = wr_addr_q;
        mem_data_out   = wr_data_q;
        dcache_wr_done = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = QUIESCE;
      end
    endcase

    if (in_burst) begin
      icache_grant = !owner_is_d_q;
      dcache_grant = owner_is_d_q;
      fill_word    = ret_cnt_q;
    end else begin
      icache_grant = 1'b0;
      dcache_grant = 1'b0;
      fill_word    = 3'd0;
    end

    // Returns may overlap the issue phase, so they are counted in both burst states.
    if (word_ret) begin
      ret_cnt_d         = ret_cnt_q + 3'd1;
      icache_data_valid = !owner_is_d_q;
      dcache_data_valid = owner_is_d_q;
      icache_fill_done  = last_ret && !owner_is_d_q;
      dcache_fill_done  = last_ret && owner_is_d_q;
    end else begin
      icache_data_valid = 1'b0;
      dcache_data_valid = 1'b0;
      icache_fill_done  = 1'b0;
      dcache_fill_done  = 1'b0;
    end
  end

endmodule
